// File: rtl/uart_tx_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_feeder: byte FIFO plus launch FSM feeding a UART transmitter.    |
// | Optional CTS launch gating is compiled in with UART_TX_CTS_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_tx_feeder #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [7:0]             wr_data_i,
  input  logic                   flush_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic                   launch_err_o,
  output logic                   idle_o,
  output logic                   uart_tx_en,
  output logic [7:0]             uart_tx_data,
`ifdef UART_TX_CTS_EN
  input  logic                   uart_cts_n,
`endif
  input  logic                   uart_tx_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic          en_q, en_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          w_full, w_empty, w_push, w_pop, w_cts_ok;

`ifdef UART_TX_CTS_EN
  // Two-flop synchronizer; resets to "not clear to send".
  logic [1:0] cts_sync_q;
  always_ff @(posedge clk) begin
    if (rst) cts_sync_q <= 2'b11;
    else     cts_sync_q <= {cts_sync_q[0], uart_cts_n};
  end
  assign w_cts_ok = ~cts_sync_q[1];
`else
  assign w_cts_ok = 1'b1;
`endif

  assign w_full  = (count_q == FULL_CNT);
  assign w_empty = (count_q == '0);
  assign w_push  = wr_en_i && !w_full && !flush_i;
  // A flush also suppresses a pop so no discarded byte can be launched.
  assign w_pop   = (state_q == S_IDLE) && !w_empty && !uart_tx_busy && w_cts_ok && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (w_push && !w_pop)      count_d = count_q + CW'(1);
      else if (!w_push && w_pop) count_d = count_q - CW'(1);
      if (wr_en_i && w_full) ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    en_d    = w_pop;
    data_d  = w_pop ? mem_q[rd_ptr_q] : data_q;
    case (state_q)
      S_IDLE:      if (w_pop) state_d = S_LAUNCH;
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
        tcnt_d  = '0;
      end
      S_WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_WAIT_DONE: if (!uart_tx_busy) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
      data_q   <= 8'h00;
      state_q  <= S_IDLE;
      tcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      en_q     <= en_d;
      data_q   <= data_d;
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign full_o       = w_full;
  assign empty_o      = w_empty;
  assign count_o      = count_q;
  assign overflow_o   = ovf_q;
  assign launch_err_o = err_q;
  assign idle_o       = w_empty && (state_q == S_IDLE) && !uart_tx_busy;
  assign uart_tx_en   = en_q;
  assign uart_tx_data = data_q;

endmodule
`default_nettype wire
